alu_mux_7seg_display: RTL

//  Registered N-bit ALU (ADD/OR/SUB/XOR) driving a time-multiplexed, multi-digit hex 7-segment display.

---
 rtl/alu_mux_7seg_display.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_mux_7seg_display.sv
// alu_mux_7seg_display
//   Registered N-bit ALU (ADD/OR/SUB/XOR) feeding a time-multiplexed hex
//   7-segment display with DIGITS digits and optional leading-zero blanking.
// Ports
//   clk, rst          clock (rising edge), async active-high reset
//   A, B, OP, load    operands, opcode (00 ADD, 01 OR, 10 SUB, 11 XOR), capture strobe
//   enable            display enable (0 = all segments and digits off)
//   result, zero      registered result (bit N = carry/borrow) and low-N-bits-zero flag
//   valid             one-cycle pulse the cycle after a load
//   a..g, dig         active-high segment drives and one-hot digit enable
module alu_mux_7seg_display #(
  parameter int N           = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 4,
  parameter int BLANK_LZ    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      A,
  input  logic [N-1:0]      B,
  input  logic [1:0]        OP,
  input  logic              load,
  input  logic              enable,
  output logic [N:0]        result,
  output logic              zero,
  output logic              valid,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              e,
  output logic              f,
  output logic              g,
  output logic [DIGITS-1:0] dig
);
  // Result is zero-extended to at least DIGITS nibbles so every digit has a nibble.
  localparam int EW = (DIGITS * 4 > N + 1) ? DIGITS * 4 : N + 1;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [N:0]          r_res;
  logic                r_zero;
  logic                r_valid;
  logic [PW-1:0]       r_pre;
  logic [IW-1:0]       r_idx;
  logic [6:0]          r_seg;   // {a,b,c,d,e,f,g}
  logic [DIGITS-1:0]   r_dig;

  logic [N:0]          w_alu;
  logic [EW-1:0]       w_ext;
  logic [3:0]          w_nib;
  logic [(1<<IW)-1:0]  w_hz;    // w_hz[k]: nibble k and everything above it are zero
  logic                w_blank;
  logic [DIGITS-1:0]   w_onehot;

  function automatic logic [6:0] f_hex(input logic [3:0] n);
    case (n)
      4'h0: f_hex = 7'b1111110;
      4'h1: f_hex = 7'b0110000;
      4'h2: f_hex = 7'b1101101;
      4'h3: f_hex = 7'b1111001;
      4'h4: f_hex = 7'b0110011;
      4'h5: f_hex = 7'b1011011;
      4'h6: f_hex = 7'b1011111;
      4'h7: f_hex = 7'b1110000;
      4'h8: f_hex = 7'b1111111;
      4'h9: f_hex = 7'b1111011;
      4'hA: f_hex = 7'b1110111;
      4'hB: f_hex = 7'b0011111;
      4'hC: f_hex = 7'b1001110;
      4'hD: f_hex = 7'b0111101;
      4'hE: f_hex = 7'b1001111;
      default: f_hex = 7'b1000111;
    endcase
  endfunction

  // SUB wraps mod 2^(N+1), so bit N doubles as the borrow (A < B).
  always_comb begin
    w_alu = '0;
    case (OP)
      2'b00:   w_alu = {1'b0, A} + {1'b0, B};
      2'b01:   w_alu = {1'b0, A | B};
      2'b10:   w_alu = {1'b0, A} - {1'b0, B};
      default: w_alu = {1'b0, A ^ B};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res   <= '0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= load;
      if (load) begin
        r_res  <= w_alu;
        r_zero <= (w_alu[N-1:0] == '0);
      end
    end
  end

  // Scan runs regardless of enable/load so re-enabling resumes mid-sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PW'(REFRESH_DIV - 1)) begin
      r_pre <= '0;
      r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  assign w_ext    = EW'(r_res);
  assign w_nib    = w_ext[{r_idx, 2'b00} +: 4];
  assign w_onehot = DIGITS'(1) << r_idx;

  genvar k;
  generate
    for (k = 0; k < (1 << IW); k++) begin : g_hz
      if (k < DIGITS) begin : g_real
        assign w_hz[k] = ~|w_ext[EW-1:4*k];
      end else begin : g_pad
        assign w_hz[k] = 1'b1;
      end
    end
  endgenerate

  assign w_blank = (BLANK_LZ != 0) && (r_idx != '0) && w_hz[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= '0;
      r_dig <= '0;
    end else if (enable) begin
      r_dig <= w_onehot;
      r_seg <= w_blank ? 7'b0 : f_hex(w_nib);
    end else begin
      r_seg <= '0;
      r_dig <= '0;
    end
  end

  assign result = r_res;
  assign zero   = r_zero;
  assign valid  = r_valid;
  assign dig    = r_dig;
  assign {a, b, c, d, e, f, g} = r_seg;
endmodule
